// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor helper used for reset defaults and software models.
package uart_pkg;

   localparam int unsigned DIV_W      = 16;
   localparam int unsigned FRAC_W     = 4;
   localparam int unsigned OVERSAMPLE = 16;

   typedef struct packed {
      logic [DIV_W-1:0]  div_int;
      logic [FRAC_W-1:0] div_frac;
   } baud_div_t;

   // Rounds clk_hz/(baud*os) to the nearest 1/2^FRAC_W, then splits it into int and fraction.
   function automatic baud_div_t baud_div(input longint unsigned clk_hz,
                                          input longint unsigned baud,
                                          input longint unsigned os);
      longint unsigned den;
      longint unsigned total;
      baud_div_t       r;
      den        = baud * os;
      total      = ((clk_hz << FRAC_W) + den / 2) / den;
      r.div_int  = DIV_W'(total >> FRAC_W);
      r.div_frac = FRAC_W'(total);
      return r;
   endfunction

endpackage

// File: rtl/frac_divider.sv
// Fractional-N clock divider: emits a one-cycle tick every div_int or div_int+1 clocks,
// with glitch-free divisor reload at the period boundary.
module frac_divider #(
   parameter int unsigned       DIV_W        = 16,
   parameter int unsigned       FRAC_W       = 4,
   parameter logic [DIV_W-1:0]  DIV_INT_DEF  = 16'd325,
   parameter logic [FRAC_W-1:0] DIV_FRAC_DEF = 4'd8
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              tick,
   output logic              busy_load
);

   logic [DIV_W-1:0]  cnt_q, cnt_d, int_act_q, int_act_d, int_pend_q, int_pend_d;
   logic [FRAC_W-1:0] frac_acc_q, frac_acc_d, frac_act_q, frac_act_d, frac_pend_q, frac_pend_d;
   logic              busy_q, busy_d, tick_q, tick_d;
   logic [DIV_W-1:0]  src_int, reload_val;
   logic [FRAC_W-1:0] src_frac, acc_sum;
   logic              carry;

   // A divisor below 2 would allow back-to-back ticks.
   function automatic logic [DIV_W-1:0] clamp_int(input logic [DIV_W-1:0] v);
      return (v < DIV_W'(2)) ? DIV_W'(2) : v;
   endfunction

   always_comb begin
      src_int          = busy_q ? int_pend_q : int_act_q;
      src_frac         = busy_q ? frac_pend_q : frac_act_q;
      {carry, acc_sum} = {1'b0, frac_acc_q} + {1'b0, src_frac};
      reload_val       = clamp_int(src_int) - DIV_W'(1) + DIV_W'(carry);

      cnt_d       = cnt_q;
      frac_acc_d  = frac_acc_q;
      int_act_d   = int_act_q;
      frac_act_d  = frac_act_q;
      int_pend_d  = int_pend_q;
      frac_pend_d = frac_pend_q;
      busy_d      = busy_q;
      tick_d      = 1'b0;

      if (!en) begin
         // Stopped: nothing is mid-period that could be cut short, so apply at once.
         if (div_load) begin
            int_act_d   = div_int;
            frac_act_d  = div_frac;
            int_pend_d  = div_int;
            frac_pend_d = div_frac;
            cnt_d       = clamp_int(div_int) - DIV_W'(1);
            frac_acc_d  = '0;
            busy_d      = 1'b0;
         end else if (busy_q) begin
            int_act_d  = int_pend_q;
            frac_act_d = frac_pend_q;
            cnt_d      = clamp_int(int_pend_q) - DIV_W'(1);
            frac_acc_d = '0;
            busy_d     = 1'b0;
         end
      end else begin
         if (cnt_q == '0) begin
            tick_d     = 1'b1;
            cnt_d      = reload_val;
            frac_acc_d = acc_sum;
            int_act_d  = src_int;
            frac_act_d = src_frac;
            busy_d     = 1'b0;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
         if (div_load) begin
            int_pend_d  = div_int;
            frac_pend_d = div_frac;
            busy_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= DIV_INT_DEF - DIV_W'(1);
         frac_acc_q  <= '0;
         int_act_q   <= DIV_INT_DEF;
         frac_act_q  <= DIV_FRAC_DEF;
         int_pend_q  <= DIV_INT_DEF;
         frac_pend_q <= DIV_FRAC_DEF;
         busy_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         frac_acc_q  <= frac_acc_d;
         int_act_q   <= int_act_d;
         frac_act_q  <= frac_act_d;
         int_pend_q  <= int_pend_d;
         frac_pend_q <= frac_pend_d;
         busy_q      <= busy_d;
         tick_q      <= tick_d;
      end
   end

   assign tick      = tick_q;
   assign busy_load = busy_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Programmable baud tick generator: oversample tick, bit tick and restartable Rx mid-bit strobe.
module baud_gen_frac #(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned BAUD_DEFAULT = 9600,
   parameter int unsigned OVERSAMPLE   = uart_pkg::OVERSAMPLE,
   parameter int unsigned DIV_W        = uart_pkg::DIV_W,
   parameter int unsigned FRAC_W       = uart_pkg::FRAC_W
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              rx_resync,
   output logic              Rxclk_en,
   output logic              Txclk_en,
   output logic              rx_sample,
   output logic              busy_load
);
   import uart_pkg::*;

   localparam int unsigned       OS_W         = $clog2(OVERSAMPLE);
   localparam baud_div_t         DIV_DEF      = baud_div(64'(CLK_HZ), 64'(BAUD_DEFAULT),
                                                         64'(OVERSAMPLE));
   localparam logic [DIV_W-1:0]  DIV_INT_DEF  = DIV_W'(DIV_DEF.div_int);
   localparam logic [FRAC_W-1:0] DIV_FRAC_DEF = FRAC_W'(DIV_DEF.div_frac);
   localparam logic [OS_W-1:0]   RX_MID       = OS_W'(OVERSAMPLE / 2 - 1);

   logic            tick;
   logic [OS_W-1:0] tx_cnt_q, rx_ph_q;

   frac_divider #(
      .DIV_W        (DIV_W),
      .FRAC_W       (FRAC_W),
      .DIV_INT_DEF  (DIV_INT_DEF),
      .DIV_FRAC_DEF (DIV_FRAC_DEF)
   ) u_frac_divider (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .en        (en),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .div_load  (div_load),
      .tick      (tick),
      .busy_load (busy_load)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt_q <= '0;
         rx_ph_q  <= '0;
      end else begin
         if (tick) tx_cnt_q <= tx_cnt_q + OS_W'(1);
         // A resync restarts the bit phase and swallows any coincident tick.
         if (rx_resync)  rx_ph_q <= '0;
         else if (tick)  rx_ph_q <= rx_ph_q + OS_W'(1);
      end
   end

   assign Rxclk_en  = tick;
   assign Txclk_en  = tick & (tx_cnt_q == '0);
   assign rx_sample = tick & (rx_ph_q == RX_MID) & ~rx_resync;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac.
module tb_baud_gen_frac;

   logic        clk_50m = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        div_load;
   logic        rx_resync;
   logic        Rxclk_en, Txclk_en, rx_sample, busy_load;

   int n_total = 0;
   int n_pass  = 0;

   baud_gen_frac dut (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .en        (en),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .div_load  (div_load),
      .rx_resync (rx_resync),
      .Rxclk_en  (Rxclk_en),
      .Txclk_en  (Txclk_en),
      .rx_sample (rx_sample),
      .busy_load (busy_load)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Counts enabled clock edges from the current negedge until Rxclk_en is seen high.
   task automatic next_tick(output int n);
      n = 0;
      do begin
         @(posedge clk_50m);
         n++;
         @(negedge clk_50m);
      end while (!Rxclk_en && n < 5000);
   endtask

   // Counts ticks (including one at the current negedge) up to and including the rx_sample tick.
   task automatic ticks_to_sample(output int k);
      int cyc;
      k   = 0;
      cyc = 0;
      while (cyc < 400) begin
         if (Rxclk_en) k++;
         if (rx_sample) break;
         @(posedge clk_50m);
         @(negedge clk_50m);
         cyc++;
      end
      if (cyc >= 400) k = -1;
   endtask

   task automatic load(input logic [15:0] di, input logic [3:0] df);
      div_int  = di;
      div_frac = df;
      div_load = 1'b1;
      @(posedge clk_50m);
      @(negedge clk_50m);
      div_load = 1'b0;
   endtask

   initial begin
      int n, sum, txc, k;
      int p[16];
      logic saw;

      rst_n = 1'b0; en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0; rx_resync = 1'b0;
      repeat (3) @(negedge clk_50m);
      check("rst_rxclk", Rxclk_en, 0);
      check("rst_txclk", Txclk_en, 0);
      check("rst_sample", rx_sample, 0);
      check("rst_busy", busy_load, 0);

      // First tick on enabled edge 325, and it is also a bit tick.
      rst_n = 1'b1; en = 1'b1;
      next_tick(n);
      check("first_latency", n, 325);
      check("first_txclk", Txclk_en, 1);

      sum = 0; txc = 0;
      for (int i = 0; i < 16; i++) begin
         next_tick(p[i]);
         sum += p[i];
         if (Txclk_en) txc++;
      end
      check("period0", p[0], 325);
      check("period1", p[1], 326);
      check("period14", p[14], 325);
      check("period15", p[15], 326);
      check("sum16", sum, 5208);
      check("tx_count16", txc, 1);
      check("tx_at_16th", Txclk_en, 1);

      // Load 434 mid-period: the 325 period in progress must finish unchanged.
      repeat (99) @(posedge clk_50m);
      @(negedge clk_50m);
      load(16'd434, 4'd0);
      check("busy_set", busy_load, 1);
      next_tick(n);
      check("old_period_kept", 100 + n, 325);
      check("busy_clear", busy_load, 0);
      next_tick(n);
      check("new_period_a", n, 434);
      next_tick(n);
      check("new_period_b", n, 434);

      // div_int=1 clamps to a 2-clock period.
      load(16'd1, 4'd0);
      next_tick(n);
      check("clamp_boundary", 1 + n, 434);
      for (int i = 0; i < 3; i++) begin
         next_tick(n);
         check("clamp_period", n, 2);
      end

      // Resync off a tick: sample on the 8th following tick.
      @(posedge clk_50m);
      @(negedge clk_50m);
      check("resync_off_tick", Rxclk_en, 0);
      rx_resync = 1'b1;
      @(posedge clk_50m);
      @(negedge clk_50m);
      rx_resync = 1'b0;
      ticks_to_sample(k);
      check("resync_sample", k, 8);

      // Resync coincident with a tick: that tick is swallowed.
      next_tick(n);
      rx_resync = 1'b1;
      #1;
      check("resync_suppress", rx_sample, 0);
      @(posedge clk_50m);
      @(negedge clk_50m);
      rx_resync = 1'b0;
      ticks_to_sample(k);
      check("resync_coinc_sample", k, 8);

      // Back to 434, then pause for 100 cycles mid-period.
      next_tick(n);
      load(16'd434, 4'd0);
      next_tick(n);
      check("reload434", n, 1);
      next_tick(n);
      check("period434", n, 434);
      repeat (50) @(posedge clk_50m);
      @(negedge clk_50m);
      en  = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_50m);
         @(negedge clk_50m);
         if (Rxclk_en || Txclk_en || rx_sample) saw = 1'b1;
      end
      check("paused_quiet", saw, 0);
      en = 1'b1;
      next_tick(n);
      check("pause_resume", 50 + n, 434);

      // Load while stopped applies immediately.
      en = 1'b0;
      load(16'd200, 4'd0);
      check("busy_stopped", busy_load, 0);
      en = 1'b1;
      next_tick(n);
      check("stopped_load_period", n, 200);

      // Reset with a pending load restores defaults.
      load(16'd434, 4'd0);
      repeat (10) @(negedge clk_50m);
      check("busy_before_rst", busy_load, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", busy_load, 0);
      check("rst_mid_rxclk", Rxclk_en, 0);
      @(negedge clk_50m);
      rst_n = 1'b1;
      next_tick(n);
      check("rst_first", n, 325);
      next_tick(n);
      check("rst_p1", n, 325);
      next_tick(n);
      check("rst_p2", n, 326);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
